// File: rtl/hazard_scoreboard.sv
// Purpose: scoreboard of in-flight destinations; yields load-use stall and EX forward selects.
// Latency: stall is combinational from ID inputs; ex_fwd_sel is registered, aligned with EX.
// Backpressure: stall holds PC and IF/ID and injects a bubble; flush overrides stall.
module hazard_scoreboard #(
   parameter int NUM_READ = 2,
   parameter int D        = 3,
   parameter int AW       = 5,
   parameter int LOAD_LAT = 2,
   parameter int SELW     = $clog2(D),
   parameter int CW       = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     id_valid,
   input  logic [AW-1:0]            id_rd,
   input  logic                     id_regwrite,
   input  logic                     id_is_load,
   input  logic [NUM_READ*AW-1:0]   id_rs,
   input  logic [NUM_READ-1:0]      id_rs_used,
   input  logic                     flush,
   output logic                     stall,
   output logic [NUM_READ*SELW-1:0] ex_fwd_sel,
   output logic [CW-1:0]            stall_count,
   output logic [D-1:0]             pipe_valid
);

   // Stage D (WB) keeps only its valid bit: the register file writes through,
   // so its rd/wr/ld are never consulted. Index k-1 holds stage k.
   logic [AW-1:0]            rd_q [D-1];
   logic [D-2:0]             wr_q;
   logic [D-2:0]             ld_q;

   logic [NUM_READ*SELW-1:0] sel_next;
   logic [NUM_READ-1:0]      load_use;
   logic                     push;

   // Per port, scan oldest to youngest so the youngest matching producer wins.
   always_comb begin
      sel_next = '0;
      load_use = '0;
      for (int p = 0; p < NUM_READ; p++) begin
         for (int k = D - 1; k >= 1; k--) begin
            if (id_rs_used[p] && (id_rs[p*AW +: AW] != '0) &&
                pipe_valid[k-1] && wr_q[k-1] && (rd_q[k-1] != '0) &&
                (rd_q[k-1] == id_rs[p*AW +: AW])) begin
               sel_next[p*SELW +: SELW] = SELW'(k);
               load_use[p]              = ld_q[k-1] && (k < LOAD_LAT);
            end
         end
      end
   end

   // Flush kills the ID instruction, so it also suppresses any stall it would cause.
   always_comb begin
      stall = id_valid && !flush && (|load_use);
      push  = id_valid && !flush && !(|load_use);
   end

   // Shift the scoreboard one stage per cycle; a non-issuing cycle enters as a bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_valid <= '0;
         wr_q       <= '0;
         ld_q       <= '0;
         ex_fwd_sel <= '0;
         for (int k = 0; k < D - 1; k++) rd_q[k] <= '0;
      end else begin
         pipe_valid <= {pipe_valid[D-2:0], push};
         wr_q[0]    <= push && id_regwrite && (id_rd != '0);
         ld_q[0]    <= push && id_is_load;
         rd_q[0]    <= push ? id_rd : '0;
         for (int k = 1; k < D - 1; k++) begin
            wr_q[k] <= wr_q[k-1];
            ld_q[k] <= ld_q[k-1];
            rd_q[k] <= rd_q[k-1];
         end
         ex_fwd_sel <= push ? sel_next : '0;
      end
   end

   // Count stalled cycles, holding at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_count <= '0;
      end else if (stall && (stall_count != '1)) begin
         stall_count <= stall_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: default instance (D=3, 2 ports) plus a D=4, 3-port,
// LOAD_LAT=3, 2-bit-counter instance for depth, port independence and saturation.
module tb_hazard_scoreboard;

   logic clk;
   logic rst;

   // Instance A: defaults
   logic        a_valid, a_wr, a_ld, a_flush;
   logic [4:0]  a_rd;
   logic [9:0]  a_rs;
   logic [1:0]  a_used;
   logic        a_stall;
   logic [3:0]  a_sel;
   logic [31:0] a_cnt;
   logic [2:0]  a_pv;

   // Instance B: D=4, NUM_READ=3, LOAD_LAT=3, CW=2
   logic        b_valid, b_wr, b_ld, b_flush;
   logic [4:0]  b_rd;
   logic [14:0] b_rs;
   logic [2:0]  b_used;
   logic        b_stall;
   logic [5:0]  b_sel;
   logic [1:0]  b_cnt;
   logic [3:0]  b_pv;

   int checks;
   int errors;
   int exp_cnt;

   hazard_scoreboard dut_a (
      .clk(clk), .rst(rst), .id_valid(a_valid), .id_rd(a_rd), .id_regwrite(a_wr),
      .id_is_load(a_ld), .id_rs(a_rs), .id_rs_used(a_used), .flush(a_flush),
      .stall(a_stall), .ex_fwd_sel(a_sel), .stall_count(a_cnt), .pipe_valid(a_pv)
   );

   hazard_scoreboard #(.NUM_READ(3), .D(4), .AW(5), .LOAD_LAT(3), .CW(2)) dut_b (
      .clk(clk), .rst(rst), .id_valid(b_valid), .id_rd(b_rd), .id_regwrite(b_wr),
      .id_is_load(b_ld), .id_rs(b_rs), .id_rs_used(b_used), .flush(b_flush),
      .stall(b_stall), .ex_fwd_sel(b_sel), .stall_count(b_cnt), .pipe_valid(b_pv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_a(input logic v, input logic [4:0] rd, input logic wr, input logic ld,
                        input logic [4:0] rs1, input logic [4:0] rs0, input logic [1:0] used);
      a_valid = v; a_rd = rd; a_wr = wr; a_ld = ld;
      a_rs = {rs1, rs0}; a_used = used; a_flush = 1'b0;
   endtask

   task automatic set_b(input logic v, input logic [4:0] rd, input logic wr, input logic ld,
                        input logic [14:0] rs, input logic [2:0] used);
      b_valid = v; b_rd = rd; b_wr = wr; b_ld = ld;
      b_rs = rs; b_used = used; b_flush = 1'b0;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drain;
      set_a(0, 0, 0, 0, 0, 0, 2'b00);
      set_b(0, 0, 0, 0, 15'd0, 3'b000);
      repeat (5) tick;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      set_a(0, 0, 0, 0, 0, 0, 2'b00);
      set_b(0, 0, 0, 0, 15'd0, 3'b000);
      #3;
      checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%0b exp=0", a_stall); end
      checks++; if (a_sel !== 4'd0) begin errors++; $display("FAIL rst_sel got=%h exp=0", a_sel); end
      checks++; if (a_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", a_cnt); end
      checks++; if (a_pv !== 3'd0) begin errors++; $display("FAIL rst_pv got=%b exp=000", a_pv); end
      @(negedge clk);
      rst = 1'b1;
      tick;
   endtask

   task automatic test_defaults;
      // addi x1,x0,5 then addi x2,x1,3
      set_a(1, 5'd1, 1, 0, 5'd0, 5'd0, 2'b01); #1;
      checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL dflt_prod_stall got=%0b exp=0", a_stall); end
      tick;
      set_a(1, 5'd2, 1, 0, 5'd0, 5'd1, 2'b01); #1;
      checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL dflt_cons_stall got=%0b exp=0", a_stall); end
      tick;
      checks++; if (a_sel !== 4'b0001) begin errors++; $display("FAIL dflt_sel got=%b exp=0001", a_sel); end
      drain;
   endtask

   task automatic test_distance;
      // one nop between producer and consumer
      set_a(1, 5'd1, 1, 0, 5'd0, 5'd0, 2'b00); tick;
      set_a(0, 0, 0, 0, 0, 0, 2'b00); tick;
      set_a(1, 5'd0, 0, 0, 5'd0, 5'd1, 2'b01); #1;
      checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL dist1_stall got=%0b exp=0", a_stall); end
      tick;
      checks++; if (a_sel !== 4'b0010) begin errors++; $display("FAIL dist1_sel got=%b exp=0010", a_sel); end
      drain;
      // two nops: producer is in WB, no forwarding
      set_a(1, 5'd1, 1, 0, 5'd0, 5'd0, 2'b00); tick;
      set_a(0, 0, 0, 0, 0, 0, 2'b00); tick; tick;
      set_a(1, 5'd0, 0, 0, 5'd0, 5'd1, 2'b01); tick;
      checks++; if (a_sel !== 4'b0000) begin errors++; $display("FAIL dist2_sel got=%b exp=0000", a_sel); end
      drain;
      // deeper instance: x7 three back on port2, x9 two back on port0
      set_b(1, 5'd7, 1, 0, 15'd0, 3'b000); tick;
      set_b(1, 5'd9, 1, 0, 15'd0, 3'b000); tick;
      set_b(0, 0, 0, 0, 15'd0, 3'b000); tick;
      set_b(1, 5'd0, 0, 0, {5'd7, 5'd0, 5'd9}, 3'b101); #1;
      checks++; if (b_stall !== 1'b0) begin errors++; $display("FAIL deep_stall got=%0b exp=0", b_stall); end
      tick;
      checks++; if (b_sel !== 6'b11_00_10) begin errors++; $display("FAIL deep_sel got=%b exp=110010", b_sel); end
      drain;
   endtask

   task automatic test_load_use;
      // lw x5 then add x6,x0,x5
      set_a(1, 5'd5, 1, 1, 5'd0, 5'd0, 2'b00); tick;
      set_a(1, 5'd6, 1, 0, 5'd5, 5'd0, 2'b11); #1;
      checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%0b exp=1", a_stall); end
      checks++; if (a_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL lu_cnt_pre got=%0d exp=%0d", a_cnt, exp_cnt); end
      tick; exp_cnt++;
      checks++; if (a_pv !== 3'b010) begin errors++; $display("FAIL lu_bubble got=%b exp=010", a_pv); end
      checks++; if (a_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL lu_cnt_post got=%0d exp=%0d", a_cnt, exp_cnt); end
      checks++; if (a_sel !== 4'b0000) begin errors++; $display("FAIL lu_sel_bubble got=%b exp=0000", a_sel); end
      #1;
      checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL lu_release got=%0b exp=0", a_stall); end
      tick;
      checks++; if (a_sel !== 4'b1000) begin errors++; $display("FAIL lu_sel got=%b exp=1000", a_sel); end
      drain;
   endtask

   task automatic test_youngest;
      // addi x3 older, lw x3 younger: load wins, stall
      set_a(1, 5'd3, 1, 0, 5'd0, 5'd0, 2'b00); tick;
      set_a(1, 5'd3, 1, 1, 5'd0, 5'd0, 2'b00); tick;
      set_a(1, 5'd0, 0, 0, 5'd0, 5'd3, 2'b01); #1;
      checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL yng_load_stall got=%0b exp=1", a_stall); end
      tick; exp_cnt++; #1;
      checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL yng_load_release got=%0b exp=0", a_stall); end
      tick;
      checks++; if (a_sel !== 4'b0010) begin errors++; $display("FAIL yng_load_sel got=%b exp=0010", a_sel); end
      drain;
      // lw x3 older, addi x3 younger: no stall, forward from stage 1
      set_a(1, 5'd3, 1, 1, 5'd0, 5'd0, 2'b00); tick;
      set_a(1, 5'd3, 1, 0, 5'd0, 5'd0, 2'b00); tick;
      set_a(1, 5'd0, 0, 0, 5'd0, 5'd3, 2'b01); #1;
      checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL yng_alu_stall got=%0b exp=0", a_stall); end
      tick;
      checks++; if (a_sel !== 4'b0001) begin errors++; $display("FAIL yng_alu_sel got=%b exp=0001", a_sel); end
      checks++; if (a_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL yng_cnt got=%0d exp=%0d", a_cnt, exp_cnt); end
      drain;
   endtask

   task automatic test_x0;
      // load targeting x0 must not create a hazard on x0 readers
      set_a(1, 5'd0, 1, 1, 5'd0, 5'd0, 2'b00); tick;
      set_a(1, 5'd0, 0, 0, 5'd0, 5'd0, 2'b11); #1;
      checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL x0_stall got=%0b exp=0", a_stall); end
      tick;
      checks++; if (a_sel !== 4'b0000) begin errors++; $display("FAIL x0_sel got=%b exp=0000", a_sel); end
      drain;
      // both ports name x4 but only port1 reads it
      set_a(1, 5'd4, 1, 0, 5'd0, 5'd0, 2'b00); tick;
      set_a(1, 5'd0, 0, 0, 5'd4, 5'd4, 2'b10); tick;
      checks++; if (a_sel !== 4'b0100) begin errors++; $display("FAIL unused_sel got=%b exp=0100", a_sel); end
      drain;
   endtask

   task automatic test_flush;
      set_a(1, 5'd8, 1, 1, 5'd0, 5'd0, 2'b00); tick;
      set_a(1, 5'd9, 1, 0, 5'd0, 5'd8, 2'b01);
      a_flush = 1'b1; #1;
      checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL fl_stall got=%0b exp=0", a_stall); end
      tick;
      checks++; if (a_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL fl_cnt got=%0d exp=%0d", a_cnt, exp_cnt); end
      checks++; if (a_sel !== 4'b0000) begin errors++; $display("FAIL fl_sel got=%b exp=0000", a_sel); end
      checks++; if (a_pv !== 3'b010) begin errors++; $display("FAIL fl_pv got=%b exp=010", a_pv); end
      drain;
   endtask

   task automatic test_saturate;
      // LOAD_LAT=3: a load stalls its dependent for two cycles
      set_b(1, 5'd5, 1, 1, 15'd0, 3'b000); tick;
      set_b(1, 5'd0, 0, 0, {5'd0, 5'd0, 5'd5}, 3'b001); #1;
      checks++; if (b_stall !== 1'b1) begin errors++; $display("FAIL sat_stall_k1 got=%0b exp=1", b_stall); end
      tick; #1;
      checks++; if (b_stall !== 1'b1) begin errors++; $display("FAIL sat_stall_k2 got=%0b exp=1", b_stall); end
      tick;
      checks++; if (b_cnt !== 2'd2) begin errors++; $display("FAIL sat_cnt2 got=%0d exp=2", b_cnt); end
      #1;
      checks++; if (b_stall !== 1'b0) begin errors++; $display("FAIL sat_stall_k3 got=%0b exp=0", b_stall); end
      tick;
      checks++; if (b_sel !== 6'b000011) begin errors++; $display("FAIL sat_sel got=%b exp=000011", b_sel); end
      drain;
      set_b(1, 5'd6, 1, 1, 15'd0, 3'b000); tick;
      set_b(1, 5'd0, 0, 0, {5'd0, 5'd0, 5'd6}, 3'b001); tick; tick;
      checks++; if (b_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt got=%0d exp=3", b_cnt); end
      drain;
   endtask

   task automatic test_async_reset;
      set_a(1, 5'd1, 1, 0, 5'd0, 5'd0, 2'b00); tick;
      set_a(1, 5'd2, 1, 1, 5'd0, 5'd1, 2'b01); tick;
      checks++; if (a_sel !== 4'b0001) begin errors++; $display("FAIL ar_pre_sel got=%b exp=0001", a_sel); end
      set_a(1, 5'd0, 0, 0, 5'd0, 5'd2, 2'b01); #1;
      checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL ar_pre_stall got=%0b exp=1", a_stall); end
      checks++; if (a_pv !== 3'b011) begin errors++; $display("FAIL ar_pre_pv got=%b exp=011", a_pv); end
      #2;
      rst = 1'b0;
      #1;
      checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL ar_stall got=%0b exp=0", a_stall); end
      checks++; if (a_sel !== 4'd0) begin errors++; $display("FAIL ar_sel got=%b exp=0000", a_sel); end
      checks++; if (a_cnt !== 32'd0) begin errors++; $display("FAIL ar_cnt got=%0d exp=0", a_cnt); end
      checks++; if (a_pv !== 3'd0) begin errors++; $display("FAIL ar_pv got=%b exp=000", a_pv); end
      checks++; if (b_cnt !== 2'd0) begin errors++; $display("FAIL ar_b_cnt got=%0d exp=0", b_cnt); end
      #2;
      rst = 1'b1;
      set_a(0, 0, 0, 0, 0, 0, 2'b00);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      exp_cnt = 0;
      test_reset;
      test_defaults;
      test_distance;
      test_load_use;
      test_youngest;
      test_x0;
      test_flush;
      test_saturate;
      test_async_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised hazard and forwarding controller for the in-order pipelined RISC-V datapath. It replaces the bench-driven ForwardA_Sel/ForwardB_Sel/Stall signals with hardware generation. It keeps a shift-register scoreboard of in-flight destination registers across D post-issue stages and supports any number of read ports and a configurable load latency. Each cycle it produces a combinational stall for the ID stage, registered per-port forward selects for the EX stage, and a stall performance counter.

Parameters:
NUM_READ, 2, number of source-operand read ports checked per instruction
D, 3, post-issue stages tracked (stage 1 = EX, stage D = WB); legal range 2..8
AW, 5, register address width (2**AW architectural registers, x0 hard-wired zero)
LOAD_LAT, 2, first stage index whose output register holds load data; legal range 1..D-1
SELW, $clog2(D), width of one forward-select field
CW, 32, stall counter width

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
id_valid  input  1  ID holds a real instruction
id_rd  input  AW  ID destination register
id_regwrite  input  1  ID instruction writes id_rd
id_is_load  input  1  ID instruction is a load
id_rs  input  NUM_READ*AW  source registers, port p at [p*AW +: AW]
id_rs_used  input  NUM_READ  port p actually reads its register
flush  input  1  branch redirect; kill the ID instruction
stall  output  1  combinational; hold PC and IF/ID, inject bubble
ex_fwd_sel  output  NUM_READ*SELW  registered forward select for the instruction in EX
stall_count  output  CW  saturating count of stalled cycles
pipe_valid  output  D  debug: valid bit of each stage entry

Behaviour:
- Stage entry k (1..D) = {valid, rd, wr, ld}. An entry is a producer iff valid & wr & rd!=0.
- Capture at stage 1: wr = id_regwrite & (id_rd!=0).
- Every posedge: entry k+1 <= entry k. Entry 1 <= ID record if id_valid & !stall & !flush; otherwise entry 1 <= all-zero (bubble).
- Match, per port p with id_rs_used[p] & id_rs[p]!=0: the youngest (lowest k) producer in stages 1..D-1 with rd==id_rs[p]. Stage D is ignored because the register file writes through in WB.
- Load-use: stall=1 iff id_valid & !flush and any port's youngest match k has ld=1 and k<LOAD_LAT. An older non-load match never clears this stall.
- Forward select: next ex_fwd_sel[p] = k of the youngest match, or 0 if there is no match. Encoding: 1=EX/MEM, 2=MEM/WB, … up to D-1. This is the register holding the producer when the consumer reaches EX.
- ex_fwd_sel loads 0 for all ports when the next entry 1 is a bubble (stall, flush, or !id_valid).
- Latency: ex_fwd_sel is valid exactly one cycle after the instruction's ID cycle, aligned with its EX cycle. stall has zero latency.
- Flush has priority over stall: during flush, stall=0, stall_count does not increment, and entry 1 becomes a bubble. Entries already at k≥1 continue and are not killed.
- stall_count increments on each posedge where stall=1 and saturates at all-ones.
- pipe_valid[k-1] = entry k valid.
- Reset (rst=0, asynchronous): all entries cleared, ex_fwd_sel=0, stall_count=0, pipe_valid=0. stall is 0 as a consequence. Reset mid-operation discards all in-flight state immediately, with no clock edge required.
- Port results are independent; two ports may select different stages in the same cycle.

Test Plan:
- Defaults: addi x1,x0,5 issued at cycle n; addi x2,x1,3 in ID at n+1 -> stall=0; at n+2 ex_fwd_sel port0=1, port1=0.
- Producer x1, one nop, consumer rs1=x1 -> port0=2. Two nops -> port0=0. Repeat with D=4, NUM_READ=3: three-deep distance -> sel=3, and port2 is checked independently.
- lw x5 then add x6,x0,x5 (rs2): stall=1 for exactly one cycle and pipe_valid shows a bubble in stage 1. stall_count 0->1. Next EX cycle port1=2.
- Youngest wins: addi x3 at k=2, lw x3 at k=1 -> stall. Swapped order (load older at k=2, addi at k=1) -> no stall, sel=1.
- x0 handling: producer rd=x0 with consumer rs=x0 -> no stall, sel=0. id_rs_used=0 on a matching port -> sel=0.
- flush asserted together with a load-use condition -> stall=0, stall_count unchanged, next ex_fwd_sel=0, pipe_valid[0]=0. Then rst pulled low between edges -> all outputs 0 immediately.
